nvdla_nocif_dram_read_cq: RTL and testbench

Read context queue sitting directly downstream of the DRAM read ingress stage. It captures one 7-bit context entry per issued AXI AR burst, stored per thread (AXI ID). It presents each thread's oldest entry to the egress stage so that returning R beats can be steered and counted per client. Storage is a per-thread circular FIFO in flops, with independent push and pop pointers per thread.

---
 rtl/nvdla_nocif_dram_read_cq_if.sv | 25 ++
 rtl/nvdla_nocif_dram_read_cq.sv | 130 +++++++++++++
 tb/tb_nvdla_nocif_dram_read_cq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvdla_nocif_dram_read_cq_if.sv
// Handshake bundle between the DRAM read ingress/egress stages and the read context queue.
// master = ingress/egress side, slave = the queue itself.
interface nvdla_nocif_dram_read_cq_if #(
    parameter int NUM_THREADS = 8,
    parameter int PD_W        = 7
);
    logic                        cq_wr_pvld;
    logic                        cq_wr_prdy;
    logic [3:0]                  cq_wr_thread_id;
    logic [PD_W-1:0]             cq_wr_pd;
    logic [NUM_THREADS-1:0]      cq_rd_pvld;
    logic [NUM_THREADS-1:0]      cq_rd_prdy;
    logic [NUM_THREADS*PD_W-1:0] cq_rd_pd;
    logic                        cq_wr_err;

    modport master (
        output cq_wr_pvld, cq_wr_thread_id, cq_wr_pd, cq_rd_prdy,
        input  cq_wr_prdy, cq_rd_pvld, cq_rd_pd, cq_wr_err
    );

    modport slave (
        input  cq_wr_pvld, cq_wr_thread_id, cq_wr_pd, cq_rd_prdy,
        output cq_wr_prdy, cq_rd_pvld, cq_rd_pd, cq_wr_err
    );
endinterface

// File: rtl/nvdla_nocif_dram_read_cq.sv
// Per-thread read context queue: one flop-based circular FIFO per AXI ID.
// Optional macro NVDLA_NOCIF_CQ_WATERMARK_EN adds the cq_hwm high-water-mark output.
module nvdla_nocif_dram_read_cq #(
    parameter int NUM_THREADS = 8,
    parameter int DEPTH       = 8,
    parameter int PD_W        = 7
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    input  logic [31:0]                 pwrbus_ram_pd,
    nvdla_nocif_dram_read_cq_if.slave   cq
`ifdef NVDLA_NOCIF_CQ_WATERMARK_EN
    ,
    output logic [4:0]                  cq_hwm
`endif
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [4:0]  NT5 = 5'(NUM_THREADS);

    // Storage lives in flops, so the RAM power-down bus has nothing to control.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    logic [15:0]   full_ext;
    logic [CW-1:0] cnt_d_all [NUM_THREADS];
    logic          wr_in_range;
    logic          err_q;

    assign wr_in_range   = {1'b0, cq.cq_wr_thread_id} < NT5;
    assign cq.cq_wr_prdy = wr_in_range ? ~full_ext[cq.cq_wr_thread_id] : 1'b1;
    assign cq.cq_wr_err  = err_q;

    for (genvar gi = 0; gi < 16; gi++) begin : g_full_pad
        if (gi >= NUM_THREADS) begin : g_pad
            assign full_ext[gi] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
        logic [PD_W-1:0] mem_q [DEPTH];
        logic [PW-1:0]   wr_ptr_q;
        logic [PW-1:0]   rd_ptr_q;
        logic [CW-1:0]   cnt_q;
        logic [CW-1:0]   cnt_d;
        logic            push;
        logic            pop;

        assign full_ext[gi] = (cnt_q == CW'(DEPTH));
        // Full is judged on the registered count, so a same-cycle pop never frees a slot for the push.
        assign push = cq.cq_wr_pvld & wr_in_range & (cq.cq_wr_thread_id == 4'(gi)) & ~full_ext[gi];
        assign pop  = cq.cq_rd_prdy[gi] & (cnt_q != '0);

        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!push && pop) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        assign cnt_d_all[gi]                 = cnt_d;
        assign cq.cq_rd_pvld[gi]             = (cnt_q != '0);
        assign cq.cq_rd_pd[gi*PD_W +: PD_W]  = mem_q[rd_ptr_q];

        always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge nvdla_core_clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= cq.cq_wr_pd;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            err_q <= 1'b0;
        end else if (cq.cq_wr_pvld && !wr_in_range) begin
            err_q <= 1'b1;
        end
    end

`ifdef NVDLA_NOCIF_CQ_WATERMARK_EN
    logic [4:0] hwm_q;
    logic [4:0] hwm_d;

    // Tracking the next-state counts lands the new maximum alongside the count itself.
    always_comb begin
        hwm_d = hwm_q;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (5'(cnt_d_all[i]) > hwm_d) begin
                hwm_d = 5'(cnt_d_all[i]);
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign cq_hwm = hwm_q;
`else
    logic unused_cnt_d;
    always_comb begin
        unused_cnt_d = 1'b0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            unused_cnt_d = unused_cnt_d ^ (^cnt_d_all[i]);
        end
    end
`endif
endmodule

// File: tb/tb_nvdla_nocif_dram_read_cq.sv
// Directed bench for the per-thread read context queue (8 threads, depth 8, 7-bit entries).
module tb_nvdla_nocif_dram_read_cq;
    localparam int NT = 8;
    localparam int PW = 7;

    logic        clk;
    logic        rstn;
    logic [31:0] pwrbus;
`ifdef NVDLA_NOCIF_CQ_WATERMARK_EN
    logic [4:0]  hwm;
`endif

    int n_cmp = 0;
    int n_err = 0;

    nvdla_nocif_dram_read_cq_if #(.NUM_THREADS(NT), .PD_W(PW)) cq ();

    nvdla_nocif_dram_read_cq #(.NUM_THREADS(NT), .DEPTH(8), .PD_W(PW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .pwrbus_ram_pd   (pwrbus),
        .cq              (cq.slave)
`ifdef NVDLA_NOCIF_CQ_WATERMARK_EN
        ,
        .cq_hwm          (hwm)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] tid, input logic [6:0] pd);
        cq.cq_wr_pvld      = 1'b1;
        cq.cq_wr_thread_id = tid;
        cq.cq_wr_pd        = pd;
        tick();
        cq.cq_wr_pvld      = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (cq.cq_rd_pvld !== 8'h00) begin
            n_err++; $display("FAIL reset_pvld got=%h want=00", cq.cq_rd_pvld);
        end
        n_cmp++;
        if (cq.cq_wr_err !== 1'b0) begin
            n_err++; $display("FAIL reset_err got=%b want=0", cq.cq_wr_err);
        end
        n_cmp++;
        if (cq.cq_wr_prdy !== 1'b1) begin
            n_err++; $display("FAIL reset_prdy got=%b want=1", cq.cq_wr_prdy);
        end
        @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        n_cmp++;
        if (cq.cq_rd_pvld !== 8'h00) begin
            n_err++; $display("FAIL post_reset_pvld got=%h want=00", cq.cq_rd_pvld);
        end
        $display("test_reset done");
    endtask

    task automatic test_first_push();
        push(4'd3, 7'h25);
        n_cmp++;
        if (cq.cq_rd_pvld !== 8'h08) begin
            n_err++; $display("FAIL first_push_pvld got=%h want=08", cq.cq_rd_pvld);
        end
        n_cmp++;
        if (cq.cq_rd_pd[3*PW +: PW] !== 7'h25) begin
            n_err++; $display("FAIL first_push_pd got=%h want=25", cq.cq_rd_pd[3*PW +: PW]);
        end
        $display("test_first_push t3 pd=25");
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) push(4'd0, 7'(i));
        cq.cq_wr_pvld      = 1'b1;
        cq.cq_wr_thread_id = 4'd0;
        cq.cq_wr_pd        = 7'h08;
        #1;
        n_cmp++;
        if (cq.cq_wr_prdy !== 1'b0) begin
            n_err++; $display("FAIL full_prdy got=%b want=0", cq.cq_wr_prdy);
        end
        cq.cq_wr_pvld = 1'b0;
        n_cmp++;
        if (cq.cq_rd_pvld !== 8'h09) begin
            n_err++; $display("FAIL fill_pvld got=%h want=09", cq.cq_rd_pvld);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cq.cq_rd_pd[0 +: PW] !== 7'(i)) begin
                n_err++; $display("FAIL drain_pd[%0d] got=%h want=%h", i, cq.cq_rd_pd[0 +: PW], 7'(i));
            end
            cq.cq_rd_prdy[0] = 1'b1;
            tick();
            cq.cq_rd_prdy[0] = 1'b0;
        end
        n_cmp++;
        if (cq.cq_rd_pvld[0] !== 1'b0) begin
            n_err++; $display("FAIL drain_empty got=%b want=0", cq.cq_rd_pvld[0]);
        end
        cq.cq_rd_prdy[0] = 1'b1;
        tick();
        cq.cq_rd_prdy[0] = 1'b0;
        n_cmp++;
        if (cq.cq_rd_pvld !== 8'h08) begin
            n_err++; $display("FAIL empty_pop_ignored got=%h want=08", cq.cq_rd_pvld);
        end
        $display("test_fill_drain t0 8 entries");
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) push(4'd1, 7'(8'h10 + i));
        cq.cq_wr_pvld      = 1'b1;
        cq.cq_wr_thread_id = 4'd1;
        cq.cq_wr_pd        = 7'h18;
        cq.cq_rd_prdy[1]   = 1'b1;
        #1;
        n_cmp++;
        if (cq.cq_wr_prdy !== 1'b0) begin
            n_err++; $display("FAIL full_pp_prdy got=%b want=0", cq.cq_wr_prdy);
        end
        tick();
        cq.cq_rd_prdy[1] = 1'b0;
        n_cmp++;
        if (cq.cq_wr_prdy !== 1'b1) begin
            n_err++; $display("FAIL after_pop_prdy got=%b want=1", cq.cq_wr_prdy);
        end
        tick();
        n_cmp++;
        if (cq.cq_wr_prdy !== 1'b0) begin
            n_err++; $display("FAIL refull_prdy got=%b want=0", cq.cq_wr_prdy);
        end
        cq.cq_wr_pvld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cq.cq_rd_pd[1*PW +: PW] !== 7'(8'h11 + i)) begin
                n_err++; $display("FAIL t1_drain[%0d] got=%h want=%h", i, cq.cq_rd_pd[1*PW +: PW], 7'(8'h11 + i));
            end
            cq.cq_rd_prdy[1] = 1'b1;
            tick();
            cq.cq_rd_prdy[1] = 1'b0;
        end
        n_cmp++;
        if (cq.cq_rd_pvld[1] !== 1'b0) begin
            n_err++; $display("FAIL t1_empty got=%b want=0", cq.cq_rd_pvld[1]);
        end
        $display("test_full_push_pop t1");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) push(4'd2, 7'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (cq.cq_rd_pvld[2] !== 1'b1 || cq.cq_rd_pd[2*PW +: PW] !== 7'(8'h40 + i)) begin
                n_err++; $display("FAIL wrap[%0d] pvld=%b pd=%h want pvld=1 pd=%h", i, cq.cq_rd_pvld[2], cq.cq_rd_pd[2*PW +: PW], 7'(8'h40 + i));
            end
            cq.cq_wr_pvld      = 1'b1;
            cq.cq_wr_thread_id = 4'd2;
            cq.cq_wr_pd        = 7'(8'h43 + i);
            cq.cq_rd_prdy[2]   = 1'b1;
            tick();
        end
        cq.cq_wr_pvld = 1'b0;
        for (int i = 20; i < 23; i++) begin
            n_cmp++;
            if (cq.cq_rd_pd[2*PW +: PW] !== 7'(8'h40 + i)) begin
                n_err++; $display("FAIL wrap_tail[%0d] got=%h want=%h", i, cq.cq_rd_pd[2*PW +: PW], 7'(8'h40 + i));
            end
            tick();
        end
        cq.cq_rd_prdy[2] = 1'b0;
        n_cmp++;
        if (cq.cq_rd_pvld !== 8'h08) begin
            n_err++; $display("FAIL wrap_end_pvld got=%h want=08", cq.cq_rd_pvld);
        end
        $display("test_wrap t2 20 cycles");
    endtask

    task automatic test_oor_and_reset();
        cq.cq_wr_pvld      = 1'b1;
        cq.cq_wr_thread_id = 4'd12;
        cq.cq_wr_pd        = 7'h55;
        #1;
        n_cmp++;
        if (cq.cq_wr_prdy !== 1'b1) begin
            n_err++; $display("FAIL oor_prdy got=%b want=1", cq.cq_wr_prdy);
        end
        n_cmp++;
        if (cq.cq_wr_err !== 1'b0) begin
            n_err++; $display("FAIL oor_err_before got=%b want=0", cq.cq_wr_err);
        end
        tick();
        cq.cq_wr_pvld = 1'b0;
        n_cmp++;
        if (cq.cq_wr_err !== 1'b1 || cq.cq_rd_pvld !== 8'h08) begin
            n_err++; $display("FAIL oor_after err=%b pvld=%h want err=1 pvld=08", cq.cq_wr_err, cq.cq_rd_pvld);
        end
        push(4'd5, 7'h33);
        n_cmp++;
        if (cq.cq_wr_err !== 1'b1 || cq.cq_rd_pvld !== 8'h28) begin
            n_err++; $display("FAIL err_sticky err=%b pvld=%h want err=1 pvld=28", cq.cq_wr_err, cq.cq_rd_pvld);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (cq.cq_rd_pvld !== 8'h00 || cq.cq_wr_err !== 1'b0) begin
            n_err++; $display("FAIL async_reset pvld=%h err=%b want pvld=00 err=0", cq.cq_rd_pvld, cq.cq_wr_err);
        end
        #3 rstn = 1'b1;
        tick();
        n_cmp++;
        if (cq.cq_rd_pvld !== 8'h00) begin
            n_err++; $display("FAIL post_reset2 got=%h want=00", cq.cq_rd_pvld);
        end
        $display("test_oor_and_reset tid=12");
    endtask

`ifdef NVDLA_NOCIF_CQ_WATERMARK_EN
    task automatic test_watermark();
        n_cmp++;
        if (hwm !== 5'd0) begin
            n_err++; $display("FAIL hwm_reset got=%0d want=0", hwm);
        end
        push(4'd4, 7'h01);
        n_cmp++;
        if (hwm !== 5'd1) begin
            n_err++; $display("FAIL hwm_one got=%0d want=1", hwm);
        end
        for (int i = 0; i < 4; i++) push(4'd4, 7'(i + 2));
        n_cmp++;
        if (hwm !== 5'd5) begin
            n_err++; $display("FAIL hwm_five got=%0d want=5", hwm);
        end
        cq.cq_rd_prdy[4] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        cq.cq_rd_prdy[4] = 1'b0;
        push(4'd6, 7'h0a);
        push(4'd6, 7'h0b);
        n_cmp++;
        if (hwm !== 5'd5 || cq.cq_rd_pvld !== 8'h40) begin
            n_err++; $display("FAIL hwm_hold hwm=%0d pvld=%h want hwm=5 pvld=40", hwm, cq.cq_rd_pvld);
        end
        $display("test_watermark hwm=%0d", hwm);
    endtask
`endif

    initial begin
        rstn               = 1'b0;
        pwrbus             = 32'h0;
        cq.cq_wr_pvld      = 1'b0;
        cq.cq_wr_thread_id = 4'd0;
        cq.cq_wr_pd        = 7'h00;
        cq.cq_rd_prdy      = 8'h00;
        test_reset();
        test_first_push();
        test_fill_drain();
        test_full_push_pop();
        test_wrap();
        test_oor_and_reset();
`ifdef NVDLA_NOCIF_CQ_WATERMARK_EN
        test_watermark();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
